// File: rtl/aes_pkg.sv
// Shared AES definitions: S-box table, word-level helpers and the key-expansion FSM states.
// Used by both the key schedule and the cipher core so there is a single S-box.
package aes_pkg;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  typedef enum logic [1:0] {IDLE, EXPAND, DONE} ke_state_e;

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[b];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] x);
    return {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] x);
    return {x[23:0], x[31:24]};
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_sub_word.sv
// Four parallel S-box lookups on one 32-bit word; purely combinational.
module aes_sub_word
  import aes_pkg::*;
(
  input  logic [31:0] din,
  output logic [31:0] dout
);

  for (genvar b = 0; b < 4; b++) begin : g_lane
    assign dout[8*b +: 8] = sbox(din[8*b +: 8]);
  end

endmodule

// File: rtl/aes_key_expand.sv
// Iterative AES key schedule: one 32-bit schedule word per cycle into a flat word store.
// Optional AES_KEY_ZEROIZE_EN adds a synchronous zeroize input that wipes the schedule.
module aes_key_expand
  import aes_pkg::*;
#(
  parameter int Nk = 4,
  parameter int Nr = Nk + 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [32*Nk-1:0]      key_in,
`ifdef AES_KEY_ZEROIZE_EN
  input  logic                  zeroize,
`endif
  output logic                  busy,
  output logic                  key_valid,
  output logic [Nr:0][127:0]    k_sch
);

  localparam int NW = 4 * (Nr + 1);
  localparam int IW = $clog2(NW);

  if (!(Nk == 4 || Nk == 6 || Nk == 8)) begin : g_bad_nk
    $error("aes_key_expand: Nk must be 4, 6 or 8");
  end

  ke_state_e     state;
  logic [31:0]   w [NW];
  logic [IW-1:0] idx;
  logic [2:0]    ph;     // idx mod Nk, tracked incrementally
  logic [7:0]    rcon;

  logic [31:0] prev, sw_in, sw_out, t, nxt;

  always_comb begin
    prev  = w[idx - IW'(1)];
    sw_in = (ph == 3'd0) ? rot_word(prev) : prev;
    t     = prev;
    if (ph == 3'd0)                  t = sw_out ^ {rcon, 24'h0};
    else if (Nk == 8 && ph == 3'd4)  t = sw_out;
    nxt   = w[idx - IW'(Nk)] ^ t;
  end

  aes_sub_word u_sub_word (
    .din  (sw_in),
    .dout (sw_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      key_valid <= 1'b0;
      rcon      <= 8'h01;
      idx       <= '0;
      ph        <= '0;
      for (int k = 0; k < NW; k++) w[k] <= '0;
    end
`ifdef AES_KEY_ZEROIZE_EN
    else if (zeroize) begin
      state     <= IDLE;
      busy      <= 1'b0;
      key_valid <= 1'b0;
      rcon      <= 8'h01;
      idx       <= '0;
      ph        <= '0;
      for (int k = 0; k < NW; k++) w[k] <= '0;
    end
`endif
    else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            for (int k = 0; k < Nk; k++) w[k] <= key_in[32*(Nk-k)-1 -: 32];
            idx       <= IW'(Nk);
            ph        <= '0;
            rcon      <= 8'h01;
            key_valid <= 1'b0;
            busy      <= 1'b1;
            state     <= EXPAND;
          end
        end
        EXPAND: begin
          w[idx] <= nxt;
          if (ph == 3'd0) rcon <= xtime(rcon);
          ph <= (ph == 3'(Nk - 1)) ? 3'd0 : 3'(ph + 3'd1);
          // last word: schedule becomes valid in the same cycle busy drops
          if (idx == IW'(NW - 1)) begin
            busy      <= 1'b0;
            key_valid <= 1'b1;
            state     <= DONE;
          end else begin
            idx <= IW'(idx + IW'(1));
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar r = 0; r <= Nr; r++) begin : g_rk
    assign k_sch[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  end

endmodule

// File: tb/tb_aes_key_expand.sv
// Directed + random checks of aes_key_expand for Nk=4/6/8 against a GF(2^8)-derived key schedule model.
module tb_aes_key_expand;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [2:0]          start;
  logic [2:0]          busy, kv;
  logic [255:0]        key_bus [3];
  logic [10:0][127:0]  ks4;
  logic [12:0][127:0]  ks6;
  logic [14:0][127:0]  ks8;
`ifdef AES_KEY_ZEROIZE_EN
  logic                zeroize;
`endif

  int nvec = 0;
  int nerr = 0;

  logic [7:0]   sbox_m [256];
  logic [127:0] exp_rk [15];

  always #5 clk = ~clk;

  aes_key_expand #(.Nk(4)) u4 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .key_in(key_bus[0][127:0]),
`ifdef AES_KEY_ZEROIZE_EN
    .zeroize(zeroize),
`endif
    .busy(busy[0]), .key_valid(kv[0]), .k_sch(ks4));

  aes_key_expand #(.Nk(6)) u6 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .key_in(key_bus[1][191:0]),
`ifdef AES_KEY_ZEROIZE_EN
    .zeroize(zeroize),
`endif
    .busy(busy[1]), .key_valid(kv[1]), .k_sch(ks6));

  aes_key_expand #(.Nk(8)) u8 (
    .clk(clk), .rst_n(rst_n), .start(start[2]), .key_in(key_bus[2]),
`ifdef AES_KEY_ZEROIZE_EN
    .zeroize(zeroize),
`endif
    .busy(busy[2]), .key_valid(kv[2]), .k_sch(ks8));

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox_calc(input logic [7:0] a);
    logic [7:0] inv = 8'h00;
    logic [7:0] s;
    if (a != 8'h00) begin
      inv = 8'h01;
      for (int i = 0; i < 254; i++) inv = gmul(inv, a);  // a^254 = a^-1
    end
    s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
            ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    return s;
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] x);
    return {sbox_m[x[31:24]], sbox_m[x[23:16]], sbox_m[x[15:8]], sbox_m[x[7:0]]};
  endfunction

  task automatic model(input int nk, input logic [255:0] key);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    int nr = nk + 6;
    for (int i = 0; i < nk; i++) w[i] = key[32*(nk-i)-1 -: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end else if (nk > 6 && i % nk == 4) begin
        t = subw(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r < 15; r++)
      exp_rk[r] = (r <= nr) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : 128'h0;
  endtask

  // ---------------- helpers ----------------
  function automatic logic [127:0] get_rk(input int s, input int r);
    case (s)
      0:       return ks4[r];
      1:       return ks6[r];
      default: return ks8[r];
    endcase
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input int s, input string tag);
    int nk = (s == 0) ? 4 : (s == 1) ? 6 : 8;
    for (int r = 0; r <= nk + 6; r++)
      chk($sformatf("%s rk%0d", tag, r), get_rk(s, r), exp_rk[r]);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, " busy"}, 128'(busy[0]), 128'h0);
    chk({tag, " kv"},   128'(kv[0]),   128'h0);
    for (int r = 0; r <= 10; r++)
      chk($sformatf("%s rk%0d", tag, r), ks4[r], 128'h0);
  endtask

  // start on instance s, count cycles to key_valid, optionally pulse start again at glitch_at
  task automatic run(input int s, input logic [255:0] key, input int lat, input string tag,
                     input bit exp_drop, input int glitch_at, input logic [255:0] gkey);
    int cnt;
    int nk = (s == 0) ? 4 : (s == 1) ? 6 : 8;
    @(negedge clk);
    key_bus[s] = key;
    start[s]   = 1'b1;
    @(negedge clk);
    start[s] = 1'b0;
    cnt      = 1;
    chk({tag, " busy"}, 128'(busy[s]), 128'h1);
    if (exp_drop) chk({tag, " drop"}, 128'(kv[s]), 128'h0);
    while (!kv[s] && cnt < 200) begin
      @(negedge clk);
      cnt++;
      if (glitch_at != 0 && cnt == glitch_at) begin
        key_bus[s] = gkey;
        start[s]   = 1'b1;
      end else begin
        start[s] = 1'b0;
      end
    end
    start[s] = 1'b0;
    chk({tag, " lat"},  128'(cnt),     128'(lat));
    chk({tag, " idle"}, 128'(busy[s]), 128'h0);
    model(nk, key);
    check_all(s, tag);
  endtask

  function automatic logic [255:0] rand_key();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < 256; i++) sbox_m[i] = sbox_calc(8'(i));
    rst_n = 1'b0;
    start = '0;
    for (int s = 0; s < 3; s++) key_bus[s] = '0;
`ifdef AES_KEY_ZEROIZE_EN
    zeroize = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check_zero("reset");
    chk("reset kv6", 128'(kv[1]), 128'h0);
    chk("reset rk8_14", ks8[14], 128'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // FIPS-197 known answers
    run(0, 256'h2b7e151628aed2a6abf7158809cf4f3c, 41, "kat128", 1'b0, 0, '0);
    chk("kat128 rk1",  ks4[1],  128'ha0fafe1788542cb123a339392a6c7605);
    chk("kat128 rk10", ks4[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    run(1, 256'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 47, "kat192", 1'b0, 0, '0);
    chk("kat192 rk12", ks6[12], 128'he98ba06f448c773c8ecc720401002202);
    run(2, 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4, 53, "kat256",
        1'b0, 0, '0);
    chk("kat256 rk14", ks8[14], 128'hfe4890d1e6188d0b046df344706c631e);

    // restart from DONE with a start pulse during expansion that must be ignored
    run(0, 256'h2b7e151628aed2a6abf7158809cf4f3c, 41, "glitch", 1'b1, 10, rand_key());
    chk("glitch rk10", ks4[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    // restart from DONE with the all-zero key
    run(0, 256'h0, 41, "zero", 1'b1, 0, '0);
    chk("zero rk10", ks4[10], 128'hb4ef5bcb3e92e21123e951cf6f8f188e);

    // random keys on every key size
    for (int n = 0; n < 3; n++) begin
      run(0, rand_key(), 41, $sformatf("rnd128_%0d", n), 1'b1, 0, '0);
      run(1, rand_key(), 47, $sformatf("rnd192_%0d", n), 1'b1, 0, '0);
      run(2, rand_key(), 53, $sformatf("rnd256_%0d", n), 1'b1, 0, '0);
    end

    // asynchronous reset in the middle of an expansion
    @(negedge clk);
    key_bus[0] = rand_key();
    start[0]   = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    repeat (14) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_zero("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (60) @(negedge clk);
    chk("midrst kv later",   128'(kv[0]),   128'h0);
    chk("midrst busy later", 128'(busy[0]), 128'h0);

`ifdef AES_KEY_ZEROIZE_EN
    run(0, rand_key(), 41, "prezero", 1'b0, 0, '0);
    @(negedge clk);
    zeroize  = 1'b1;
    start[0] = 1'b1;
    @(negedge clk);
    zeroize  = 1'b0;
    start[0] = 1'b0;
    check_zero("zeroize");
    repeat (5) @(negedge clk);
    chk("zeroize stays idle", 128'(busy[0]), 128'h0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
